frame_loader: RTL and testbench
===============================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 6: frame edge length in pixels; frame is square.
REQ-002 SHALL have parameter PX_SIZE, default 8: bits per unsigned pixel.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_px holds a valid pixel.
REQ-006 SHALL have port in_ready, output, 1: block accepts a pixel this cycle; a beat transfers when in_valid and in_ready are both 1.
REQ-007 SHALL have port in_px, input, PX_SIZE: pixel, raster order, row-major.
REQ-008 SHALL have port in_last, input, 1: source marks the final pixel of a frame; checked only.
REQ-009 SHALL have port out_img, output, [INPUT_SIZE][INPUT_SIZE][PX_SIZE] packed: frame bus; out_img[r][c] is pixel at row r, column c, as consumed by pool_layer img_in.
REQ-010 SHALL have port out_valid, output, 1: out_img holds a complete frame.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the frame when out_valid and out_ready are both 1.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on in_last mismatch.

Function
REQ-013 SHALL keep row and col counters, each 0..INPUT_SIZE-1; an accepted beat writes in_px to load bank [row][col], then col increments, wrapping to 0 with row increment at col=INPUT_SIZE-1.
REQ-014 SHALL use state LOAD (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1), registered.
REQ-015 SHALL move LOAD->HOLD on acceptance at row=col=INPUT_SIZE-1; out_valid SHALL be 1 the cycle after that edge (latency 1 cycle from final beat), and row/col SHALL return to 0 on that edge.
REQ-016 SHALL move HOLD->LOAD on the edge where out_ready=1; out_valid SHALL be 0 the next cycle.
REQ-017 SHALL keep out_img stable for every cycle out_valid=1 until the handshake edge.
REQ-018 SHALL pulse frame_err for one cycle after an accepted beat where in_last=1 at a non-final position or in_last=0 at the final position; framing SHALL follow position counters only.
REQ-019 SHALL ignore in_valid when in_ready=0; in_px and in_last SHALL have no effect then.
REQ-020 SHALL accept out_ready at any time; out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-021 SHALL, while rst_n=0, force state LOAD, row=col=0, out_valid=0, frame_err=0, in_ready=0, all bank bits 0 (out_img=0), active-bank select 0.
REQ-022 SHALL assert in_ready=1 the first cycle after rst_n rises; reset mid-frame SHALL discard partial frame and held frame.

Configuration
REQ-023 SHALL, when FRAME_LOADER_PINGPONG_EN is defined, use two banks: out_img shows held bank; loading continues into the other; in_ready=0 only while both banks are full.
REQ-024 SHALL, with FRAME_LOADER_PINGPONG_EN, when the final beat and the out_ready handshake fall on the same edge, keep out_valid=1 and present the newly loaded bank the next cycle.
REQ-025 SHALL, with FRAME_LOADER_PINGPONG_EN, when the final beat lands while a frame is still held, retain it and present it the cycle after the held frame's handshake.
REQ-026 SHALL, without FRAME_LOADER_PINGPONG_EN, use one bank and the REQ-014..016 behaviour exactly.

Verification
REQ-027 SHALL cover: INPUT_SIZE=6, PX_SIZE=8, 36 back-to-back beats px=n (n=0..35), in_last on beat 35 -> out_valid high 1 cycle after beat 35, out_img[2][3]=15, out_img[5][5]=35, frame_err never 1.
REQ-028 SHALL cover: in_last=1 on beat 10 and 0 on beat 35 -> frame_err pulses twice, one cycle each; frame completes at beat 35.
REQ-029 SHALL cover: out_ready held 0 for 20 cycles after frame completes, in_valid=1 -> single-bank: in_ready=0, out_img unchanged for 20 cycles; out_ready=1 -> in_ready=1 next cycle.
REQ-030 SHALL cover: rst_n pulsed low after beat 17 -> out_img=0, out_valid=0; next 36 beats px=100+n -> out_img[0][0]=100.
REQ-031 SHALL cover: FRAME_LOADER_PINGPONG_EN, two frames streamed continuously, out_ready=1 on same edge as frame 2 final beat -> out_valid stays 1, out_img[0][0] switches to frame 2 value, no stall on in_ready.
REQ-032 SHALL cover: in_valid toggled randomly 50% with out_ready=1 -> frames match raster order, no beat lost or duplicated.

Source files
------------

// File: rtl/frame_loader.sv
`timescale 1ns/1ps
// frame_loader
//   Collects a square frame of INPUT_SIZE x INPUT_SIZE pixels arriving one per
//   beat in raster (row-major) order. The frame is then presented as one wide
//   bus until the consumer accepts it.
//
// Parameters
//   INPUT_SIZE : frame edge length in pixels (the frame is square)
//   PX_SIZE    : bits per unsigned pixel
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset; discards partial and held frames
//   in_valid   : in_px carries a pixel
//   in_ready   : a beat transfers when in_valid && in_ready
//   in_px      : pixel value
//   in_last    : source marker for the final pixel; only checked, never trusted
//   out_img    : out_img[r][c] is the pixel at row r, column c
//   out_valid  : out_img holds a complete frame
//   out_ready  : the frame is taken when out_valid && out_ready
//   frame_err  : one-cycle pulse after a beat whose in_last disagrees with the
//                position counters
//
// Build option
//   FRAME_LOADER_PINGPONG_EN : when defined, two banks are used, so the next
//   frame loads while the previous one is held. Otherwise there is a single
//   bank and loading pauses while a frame is held.
module frame_loader #(
  parameter int INPUT_SIZE = 6,
  parameter int PX_SIZE    = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [PX_SIZE-1:0]                             in_px,
  input  logic                                           in_last,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][PX_SIZE-1:0] out_img,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           frame_err
);

  localparam int            CW   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  logic [CW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  // Low while reset is applied and for the first edge after it, so in_ready
  // stays 0 during reset and rises only after the first clock edge.
  logic          alive_reg;
  logic          frame_err_reg;
  logic          accept;
  logic          at_final;
  logic          frame_done;
  logic          wr0;

  assign accept     = in_valid & in_ready;
  assign at_final   = (row_reg == LAST) && (col_reg == LAST);
  assign frame_done = accept & at_final;
  assign frame_err  = frame_err_reg;

  // Raster position of the next beat. Framing is driven only by these
  // counters; in_last is compared against them and does not affect them.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (accept) begin
      if (col_reg == LAST) begin
        col_next = '0;
        row_next = (row_reg == LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg       <= '0;
      col_reg       <= '0;
      alive_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      row_reg       <= row_next;
      col_reg       <= col_next;
      alive_reg     <= 1'b1;
      frame_err_reg <= accept & (in_last ^ at_final);
    end
  end

`ifdef FRAME_LOADER_PINGPONG_EN
  // full_reg[b] marks bank b as a completed frame. load_sel_reg is the bank
  // being filled. held_sel_reg is the bank shown on out_img. held_sel_reg
  // advances on every handshake, so it always points at the oldest complete
  // frame, or at the bank currently loading when no frame is complete.
  logic [1:0] full_reg, full_next;
  logic       load_sel_reg, load_sel_next;
  logic       held_sel_reg, held_sel_next;
  logic       handshake;
  logic       wr1;

  assign out_valid = full_reg[held_sel_reg];
  assign in_ready  = alive_reg & ~(&full_reg);
  assign handshake = out_valid & out_ready;
  assign wr0       = accept & ~load_sel_reg;
  assign wr1       = accept &  load_sel_reg;

  // When a handshake and a final beat fall on the same edge, they touch
  // different banks. The freed bank is the held one, and the filled bank is
  // the other one. The filled bank becomes the held bank directly, so
  // out_valid stays high.
  always_comb begin
    full_next     = full_reg;
    load_sel_next = load_sel_reg;
    held_sel_next = held_sel_reg;
    if (handshake) begin
      full_next[held_sel_reg] = 1'b0;
      held_sel_next           = ~held_sel_reg;
    end
    if (frame_done) begin
      full_next[load_sel_reg] = 1'b1;
      load_sel_next           = ~load_sel_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg     <= 2'b00;
      load_sel_reg <= 1'b0;
      held_sel_reg <= 1'b0;
    end else begin
      full_reg     <= full_next;
      load_sel_reg <= load_sel_next;
      held_sel_reg <= held_sel_next;
    end
  end
`else
  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;
  state_t state_reg, state_next;

  assign in_ready  = alive_reg & (state_reg == LOAD);
  assign out_valid = (state_reg == HOLD);
  assign wr0       = accept;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (frame_done) state_next = HOLD;
      HOLD:    if (out_ready)  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LOAD;
    else        state_reg <= state_next;
  end
`endif

  // Pixel storage: each cell is a flop, written only by the beat whose raster
  // position matches its coordinates.
  for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_row
    for (genvar gc = 0; gc < INPUT_SIZE; gc++) begin : g_col
      logic               hit;
      logic [PX_SIZE-1:0] cell0_reg;

      assign hit = (row_reg == CW'(gi)) && (col_reg == CW'(gc));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cell0_reg <= '0;
        else if (wr0 && hit) cell0_reg <= in_px;
      end

`ifdef FRAME_LOADER_PINGPONG_EN
      logic [PX_SIZE-1:0] cell1_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cell1_reg <= '0;
        else if (wr1 && hit) cell1_reg <= in_px;
      end

      assign out_img[gi][gc] = held_sel_reg ? cell1_reg : cell0_reg;
`else
      assign out_img[gi][gc] = cell0_reg;
`endif
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
`timescale 1ns/1ps
module tb_frame_loader;
  localparam int N    = 6;
  localparam int P    = 8;
  localparam int NPX  = N * N;
  localparam int IMGW = N * N * P;
`ifdef FRAME_LOADER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef logic [N-1:0][N-1:0][P-1:0] img_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [P-1:0] in_px = '0;
  logic         in_ready, out_valid, frame_err;
  img_t         out_img;

  int pass_cnt = 0;
  int total_cnt = 0;
  int err_pulses = 0;
  int hs_count = 0;
  int stall_cnt = 0;

  frame_loader #(.INPUT_SIZE(N), .PX_SIZE(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_px(in_px), .in_last(in_last), .out_img(out_img),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Behavioural model. Completed frames wait in a queue, which holds at most
  // CAP of them. Beats are accepted only while the queue has room, and the
  // head of the queue is what the consumer sees.
  img_t frames_q[$];
  img_t partial = '0;
  int   beats = 0;
  bit   alive = 1'b0;
  bit   exp_err = 1'b0;

  function automatic bit m_ready();
    return alive && (frames_q.size() < CAP);
  endfunction

  function automatic bit m_valid();
    return frames_q.size() > 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q.delete();
      partial = '0;
      beats   = 0;
      alive   = 1'b0;
      exp_err = 1'b0;
    end else begin
      bit acc, hs;
      acc     = in_valid && m_ready();
      hs      = m_valid() && out_ready;
      exp_err = acc && (in_last != (beats == NPX - 1));
      if (hs) begin
        $display("frame %0d delivered: px[0][0]=%0d px[5][5]=%0d", hs_count,
                 frames_q[0][0][0], frames_q[0][N-1][N-1]);
        void'(frames_q.pop_front());
        hs_count++;
      end
      if (acc) begin
        partial[beats / N][beats % N] = in_px;
        beats++;
        if (beats == NPX) begin
          frames_q.push_back(partial);
          beats = 0;
        end
      end
      alive = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic chkimg(input string name, input logic [IMGW-1:0] act, input logic [IMGW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Per-cycle comparison against the model, taken on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst frame_err", 32'(frame_err), 32'd0);
      chkimg("rst out_img", out_img, '0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid()));
      chk("frame_err", 32'(frame_err), 32'(exp_err));
      if (m_valid()) chkimg("out_img", out_img, frames_q[0]);
    end
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [P-1:0] px, input logic last);
    logic r;
    in_valid = 1'b1;
    in_px    = px;
    in_last  = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      stall_cnt++;
    end
    total_cnt++;
    $display("FAIL send_beat timeout at %0t: got in_ready=0 for 200 cycles, expected acceptance", $time);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int last_at, input bit last_final);
    for (int n = 0; n < NPX; n++)
      send_beat(P'(base + n), (n == last_at) || (last_final && n == NPX - 1));
  endtask

  task automatic deliver();
    for (int k = 0; k < 100 && !out_valid; k++) tick();
    if (!out_valid) begin
      total_cnt++;
      $display("FAIL deliver timeout at %0t: got out_valid=0, expected 1", $time);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish, expected end of test", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, h0, seen;
    tick();
    tick();
    rst_n = 1'b1;

    // Frame of px=n, in_last on beat 35. out_valid must rise one cycle after
    // the final beat.
    for (int n = 0; n < NPX - 1; n++) send_beat(P'(n), 1'b0);
    chk("t1 valid before final", 32'(out_valid), 32'd0);
    send_beat(8'd35, 1'b1);
    chk("t1 valid after final", 32'(out_valid), 32'd1);
    chk("t1 px[2][3]", 32'(out_img[2][3]), 32'd15);
    chk("t1 px[5][5]", 32'(out_img[5][5]), 32'd35);
    chk("t1 px[0][0]", 32'(out_img[0][0]), 32'd0);
`ifndef FRAME_LOADER_PINGPONG_EN
    chk("t1 ready while held", 32'(in_ready), 32'd0);
`endif
    deliver();
    chk("t1 no frame_err", 32'(err_pulses), 32'd0);

    // in_last misplaced on beat 10 and missing on beat 35.
    e0 = err_pulses;
    send_frame(20, 10, 1'b0);
    tick();
    chk("t2 err pulses", 32'(err_pulses - e0), 32'd2);
    chk("t2 frame complete", 32'(out_valid), 32'd1);
    chk("t2 px[1][4]", 32'(out_img[1][4]), 32'd30);
    deliver();

`ifndef FRAME_LOADER_PINGPONG_EN
    // Consumer stalls 20 cycles while the source keeps offering data.
    send_frame(200, -1, 1'b1);
    in_valid = 1'b1;
    in_px    = 8'd77;
    seen     = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (in_ready) seen++;
    end
    chk("t3 ready during stall", 32'(seen), 32'd0);
    chk("t3 px[5][5] held", 32'(out_img[5][5]), 32'd235);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3 ready after handshake", 32'(in_ready), 32'd1);
    chk("t3 valid after handshake", 32'(out_valid), 32'd0);
`else
    // Two continuous frames. The handshake falls on the same edge as
    // frame 2's final beat.
    stall_cnt = 0;
    send_frame(0, -1, 1'b1);
    for (int n = 0; n < NPX - 1; n++) send_beat(P'(50 + n), 1'b0);
    chk("t3 frame1 shown", 32'(out_img[0][0]), 32'd0);
    out_ready = 1'b1;
    send_beat(8'd85, 1'b1);
    out_ready = 1'b0;
    chk("t3 valid kept", 32'(out_valid), 32'd1);
    chk("t3 frame2 px[0][0]", 32'(out_img[0][0]), 32'd50);
    chk("t3 frame2 px[5][5]", 32'(out_img[5][5]), 32'd85);
    chk("t3 no stall", 32'(stall_cnt), 32'd0);
    deliver();
    // A second frame finishes while the first is still held. It must be
    // presented only after the first is taken.
    send_frame(150, -1, 1'b1);
    send_frame(180, -1, 1'b1);
    chk("t3 both full ready", 32'(in_ready), 32'd0);
    chk("t3 older shown", 32'(out_img[0][0]), 32'd150);
    deliver();
    chk("t3 newer valid", 32'(out_valid), 32'd1);
    chk("t3 newer shown", 32'(out_img[0][0]), 32'd180);
    deliver();
`endif

    // Reset in mid-frame after beat 17.
    for (int n = 0; n < 18; n++) send_beat(P'(n), 1'b0);
    rst_n = 1'b0;
    #1;
    chkimg("t4 img in reset", out_img, '0);
    chk("t4 valid in reset", 32'(out_valid), 32'd0);
    chk("t4 ready in reset", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("t4 ready before edge", 32'(in_ready), 32'd0);
    tick();
    chk("t4 ready after edge", 32'(in_ready), 32'd1);
    send_frame(100, -1, 1'b1);
    chk("t4 px[0][0]", 32'(out_img[0][0]), 32'd100);
    chk("t4 px[5][5]", 32'(out_img[5][5]), 32'd135);
    deliver();

    // Random 50% in_valid with out_ready held high. The model checks the
    // contents of all three frames.
    out_ready = 1'b1;
    h0 = hs_count;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < NPX; n++) begin
        for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) tick();
        send_beat(P'($urandom), n == NPX - 1);
      end
    end
    repeat (4) tick();
    out_ready = 1'b0;
    chk("t6 frames delivered", 32'(hs_count - h0), 32'd3);
    chk("t6 idle after", 32'(out_valid), 32'd0);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
